// File: rtl/prio_enc_disp.sv
// Priority encoder on a synchronized switch vector, with a new-winner counter
// and active-low seven-segment hex decoders for the index and the count.
module prio_enc_disp #(
  parameter int  N         = 8,
  parameter int  LOW_FIRST = 0,
  localparam int IDX_W     = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sw,
  input  logic             en,
  input  logic             hold,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [7:0]       cnt,
  output logic [6:0]       seg_idx,
  output logic [6:0]       seg_cnt_lo,
  output logic [6:0]       seg_cnt_hi
);

  logic [N-1:0]     s1_q, s1_d;
  logic [N-1:0]     s2_q, s2_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             new_winner;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Plain two-flop synchronizer; sw is asynchronous to clk.
  always_comb begin
    s1_d = sw;
    s2_d = s1_q;
  end

  // The last matching index in scan order wins, so the scan direction picks the priority.
  always_comb begin
    win_idx = '0;
    if (LOW_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (s2_q[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2_q[i]) win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    any_req    = en && (|s2_q);
    idx_d      = idx_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    new_winner = 1'b0;
    if (!hold) begin
      valid_d    = any_req;
      idx_d      = any_req ? win_idx : '0;
      new_winner = any_req && ({valid_d, idx_d} != {valid_q, idx_q});
    end
    // Clear beats both hold and a coincident increment.
    if (clr) begin
      cnt_d = 8'h00;
    end else if (new_winner) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx        = idx_q;
  assign valid      = valid_q;
  assign cnt        = cnt_q;
  assign seg_idx    = valid_q ? hex_glyph(4'(idx_q)) : 7'h7F;
  assign seg_cnt_lo = hex_glyph(cnt_q[3:0]);
  assign seg_cnt_hi = hex_glyph(cnt_q[7:4]);

endmodule

// File: tb/tb_prio_enc_disp.sv
// Bench for prio_enc_disp: four configurations (8/high, 8/low, 16, 2) checked
// against a queue-based behavioural model plus directed boundary scenarios.
module tb_prio_enc_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, hold, clr;
  logic [7:0]  sw8;
  logic [15:0] sw16;
  logic [1:0]  sw2;

  logic [2:0] idx_a, idx_b;
  logic [3:0] idx_c;
  logic [0:0] idx_d;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [6:0] si_a, si_b, si_c, si_d;
  logic [6:0] lo_a, lo_b, lo_c, lo_d;
  logic [6:0] hi_a, hi_b, hi_c, hi_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prio_enc_disp #(.N(8), .LOW_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sw(sw8), .en(en), .hold(hold), .clr(clr),
    .idx(idx_a), .valid(valid_a), .cnt(cnt_a),
    .seg_idx(si_a), .seg_cnt_lo(lo_a), .seg_cnt_hi(hi_a));

  prio_enc_disp #(.N(8), .LOW_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw(sw8), .en(en), .hold(hold), .clr(clr),
    .idx(idx_b), .valid(valid_b), .cnt(cnt_b),
    .seg_idx(si_b), .seg_cnt_lo(lo_b), .seg_cnt_hi(hi_b));

  prio_enc_disp #(.N(16), .LOW_FIRST(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .sw(sw16), .en(en), .hold(hold), .clr(clr),
    .idx(idx_c), .valid(valid_c), .cnt(cnt_c),
    .seg_idx(si_c), .seg_cnt_lo(lo_c), .seg_cnt_hi(hi_c));

  prio_enc_disp #(.N(2), .LOW_FIRST(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .sw(sw2), .en(en), .hold(hold), .clr(clr),
    .idx(idx_d), .valid(valid_d), .cnt(cnt_d),
    .seg_idx(si_d), .seg_cnt_lo(lo_d), .seg_cnt_hi(hi_d));

  logic [3:0] got_idx   [4];
  logic       got_valid [4];
  logic [7:0] got_cnt   [4];
  logic [6:0] got_si    [4];
  logic [6:0] got_lo    [4];
  logic [6:0] got_hi    [4];

  assign got_idx[0] = {1'b0, idx_a};
  assign got_idx[1] = {1'b0, idx_b};
  assign got_idx[2] = idx_c;
  assign got_idx[3] = {3'b000, idx_d};
  assign got_valid[0] = valid_a;
  assign got_valid[1] = valid_b;
  assign got_valid[2] = valid_c;
  assign got_valid[3] = valid_d;
  assign got_cnt[0] = cnt_a;
  assign got_cnt[1] = cnt_b;
  assign got_cnt[2] = cnt_c;
  assign got_cnt[3] = cnt_d;
  assign got_si[0] = si_a;
  assign got_si[1] = si_b;
  assign got_si[2] = si_c;
  assign got_si[3] = si_d;
  assign got_lo[0] = lo_a;
  assign got_lo[1] = lo_b;
  assign got_lo[2] = lo_c;
  assign got_lo[3] = lo_d;
  assign got_hi[0] = hi_a;
  assign got_hi[1] = hi_b;
  assign got_hi[2] = hi_c;
  assign got_hi[3] = hi_d;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
     12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Highest set bit is floor(log2 v); lowest is found by isolating v & -v first.
  function automatic int winner(input int v, input bit low);
    int x;
    int w;
    w = 0;
    x = low ? (v & -v) : v;
    while (x > 1) begin
      x = x >> 1;
      w++;
    end
    return w;
  endfunction

  // Reference model: the winner at an edge is computed from the sw value sampled two edges earlier.
  int hist8[$];
  int hist16[$];
  int hist2[$];
  int m_idx   [4];
  int m_valid [4];
  int m_cnt   [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist8.delete();
      hist16.delete();
      hist2.delete();
      for (int i = 0; i < 4; i++) begin
        m_idx[i]   = 0;
        m_valid[i] = 0;
        m_cnt[i]   = 0;
      end
    end else begin
      hist8.push_back(int'(sw8));
      hist16.push_back(int'(sw16));
      hist2.push_back(int'(sw2));
      for (int i = 0; i < 4; i++) begin
        int v;
        int nv;
        int ni;
        if (i < 2)       v = (hist8.size()  >= 3) ? hist8[hist8.size() - 3]   : 0;
        else if (i == 2) v = (hist16.size() >= 3) ? hist16[hist16.size() - 3] : 0;
        else             v = (hist2.size()  >= 3) ? hist2[hist2.size() - 3]   : 0;
        nv = (en && v != 0) ? 1 : 0;
        ni = (nv != 0) ? winner(v, i == 1) : 0;
        if (clr) m_cnt[i] = 0;
        else if (!hold && nv != 0 && (m_valid[i] != 1 || m_idx[i] != ni)) m_cnt[i] = (m_cnt[i] + 1) % 256;
        if (!hold) begin
          m_valid[i] = nv;
          m_idx[i]   = ni;
        end
      end
      while (hist8.size()  > 3) void'(hist8.pop_front());
      while (hist16.size() > 3) void'(hist16.pop_front());
      while (hist2.size()  > 3) void'(hist2.pop_front());
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_idx[i] !== 4'h0 || got_valid[i] !== 1'b0 || got_cnt[i] !== 8'h00) begin
        bad++;
        $display("[TB] FAIL reset_state[%0d] got idx=%h valid=%b cnt=%h exp 0/0/00", i, got_idx[i], got_valid[i], got_cnt[i]);
      end
      total++;
      if (got_si[i] !== 7'h7F || got_lo[i] !== 7'h40 || got_hi[i] !== 7'h40) begin
        bad++;
        $display("[TB] FAIL reset_seg[%0d] got %h/%h/%h exp 7f/40/40", i, got_si[i], got_lo[i], got_hi[i]);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    sw8   = 8'b0010_1001;
    sw16  = 16'h8000;
    sw2   = 2'b11;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
        bad++;
        $display("[TB] FAIL early_valid got a=%b b=%b exp 0", valid_a, valid_b);
      end
    end
    @(negedge clk);
    total++;
    if (idx_a !== 3'd5 || valid_a !== 1'b1 || cnt_a !== 8'd1 || si_a !== 7'h12) begin
      bad++;
      $display("[TB] FAIL high_first got idx=%0d valid=%b cnt=%0d seg=%h exp 5/1/1/12", idx_a, valid_a, cnt_a, si_a);
    end
    total++;
    if (idx_b !== 3'd0 || valid_b !== 1'b1 || si_b !== 7'h40) begin
      bad++;
      $display("[TB] FAIL low_first got idx=%0d valid=%b seg=%h exp 0/1/40", idx_b, valid_b, si_b);
    end
    total++;
    if (idx_c !== 4'hF || si_c !== 7'h0E) begin
      bad++;
      $display("[TB] FAIL n16_top got idx=%h seg=%h exp f/0e", idx_c, si_c);
    end
    total++;
    if (idx_d !== 1'b1 || valid_d !== 1'b1) begin
      bad++;
      $display("[TB] FAIL n2_both got idx=%0d valid=%b exp 1/1", idx_d, valid_d);
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    @(negedge clk);
    total++;
    if (valid_a !== 1'b0 || idx_a !== 3'd0 || si_a !== 7'h7F || cnt_a !== 8'd1) begin
      bad++;
      $display("[TB] FAIL en_off got valid=%b idx=%0d seg=%h cnt=%0d exp 0/0/7f/1", valid_a, idx_a, si_a, cnt_a);
    end
    en = 1'b1;
    @(negedge clk);
    total++;
    if (valid_a !== 1'b1 || idx_a !== 3'd5 || cnt_a !== 8'd2) begin
      bad++;
      $display("[TB] FAIL en_rerise got valid=%b idx=%0d cnt=%0d exp 1/5/2", valid_a, idx_a, cnt_a);
    end
  endtask

  task automatic test_hold();
    sw8 = 8'h01;
    repeat (3) @(negedge clk);
    total++;
    if (idx_a !== 3'd0 || valid_a !== 1'b1 || cnt_a !== 8'd3) begin
      bad++;
      $display("[TB] FAIL pre_hold got idx=%0d valid=%b cnt=%0d exp 0/1/3", idx_a, valid_a, cnt_a);
    end
    hold = 1'b1;
    sw8  = 8'h80;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (idx_a !== 3'd0 || cnt_a !== 8'd3) begin
        bad++;
        $display("[TB] FAIL held cycle %0d got idx=%0d cnt=%0d exp 0/3", k, idx_a, cnt_a);
      end
    end
    hold = 1'b0;
    @(negedge clk);
    total++;
    if (idx_a !== 3'd7 || cnt_a !== 8'd4) begin
      bad++;
      $display("[TB] FAIL hold_release got idx=%0d cnt=%0d exp 7/4", idx_a, cnt_a);
    end
  endtask

  task automatic test_wrap_clear();
    int guard;
    guard = 0;
    while (m_cnt[0] != 255 && guard < 600) begin
      sw8 = (sw8 == 8'h01) ? 8'h02 : 8'h01;
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 600) begin
      bad++;
      $display("[TB] FAIL wrap_reach model cnt=%0d exp 255 within 600 cycles", m_cnt[0]);
    end
    total++;
    if (cnt_a !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL cnt_ff got %h exp ff", cnt_a);
    end
    sw8 = (sw8 == 8'h01) ? 8'h02 : 8'h01;
    @(negedge clk);
    total++;
    if (cnt_a !== 8'h00 || lo_a !== 7'h40 || hi_a !== 7'h40) begin
      bad++;
      $display("[TB] FAIL wrap got cnt=%h lo=%h hi=%h exp 00/40/40", cnt_a, lo_a, hi_a);
    end
    sw8 = (sw8 == 8'h01) ? 8'h02 : 8'h01;
    @(negedge clk);
    total++;
    if (cnt_a !== 8'h01) begin
      bad++;
      $display("[TB] FAIL post_wrap got cnt=%h exp 01", cnt_a);
    end
    sw8 = (sw8 == 8'h01) ? 8'h02 : 8'h01;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (cnt_a !== 8'h00 || lo_a !== 7'h40) begin
      bad++;
      $display("[TB] FAIL clr_vs_inc got cnt=%h lo=%h exp 00/40", cnt_a, lo_a);
    end
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sw8   = 8'h01;
    repeat (3) @(negedge clk);
    sw8 = 8'h02;
    repeat (3) @(negedge clk);
    sw8 = 8'h04;
    repeat (3) @(negedge clk);
    total++;
    if (cnt_a !== 8'd3 || valid_a !== 1'b1 || idx_a !== 3'd2) begin
      bad++;
      $display("[TB] FAIL pre_async got cnt=%0d valid=%b idx=%0d exp 3/1/2", cnt_a, valid_a, idx_a);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (idx_a !== 3'd0 || valid_a !== 1'b0 || cnt_a !== 8'd0 || si_a !== 7'h7F || lo_a !== 7'h40 || hi_a !== 7'h40) begin
      bad++;
      $display("[TB] FAIL async_clear got idx=%0d valid=%b cnt=%0d seg=%h/%h/%h exp 0/0/0/7f/40/40", idx_a, valid_a, cnt_a, si_a, lo_a, hi_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (valid_a !== 1'b0 || cnt_a !== 8'd0) begin
        bad++;
        $display("[TB] FAIL relatency_early got valid=%b cnt=%0d exp 0/0", valid_a, cnt_a);
      end
    end
    @(negedge clk);
    total++;
    if (valid_a !== 1'b1 || idx_a !== 3'd2 || cnt_a !== 8'd1) begin
      bad++;
      $display("[TB] FAIL relatency got valid=%b idx=%0d cnt=%0d exp 1/2/1", valid_a, idx_a, cnt_a);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        logic [6:0] exp_si;
        exp_si = (m_valid[i] != 0) ? glyph(m_idx[i]) : 7'h7F;
        total++;
        if (got_idx[i] !== 4'(m_idx[i]) || got_valid[i] !== 1'(m_valid[i])) begin
          bad++;
          $display("[TB] FAIL rand_idx[%0d] cyc %0d got idx=%0d valid=%b exp %0d/%0d", i, c, got_idx[i], got_valid[i], m_idx[i], m_valid[i]);
        end
        total++;
        if (got_cnt[i] !== 8'(m_cnt[i])) begin
          bad++;
          $display("[TB] FAIL rand_cnt[%0d] cyc %0d got %0d exp %0d", i, c, got_cnt[i], m_cnt[i]);
        end
        total++;
        if (got_si[i] !== exp_si || got_lo[i] !== glyph(m_cnt[i] % 16) || got_hi[i] !== glyph(m_cnt[i] / 16)) begin
          bad++;
          $display("[TB] FAIL rand_seg[%0d] cyc %0d got %h/%h/%h exp %h/%h/%h", i, c, got_si[i], got_lo[i], got_hi[i],
                   exp_si, glyph(m_cnt[i] % 16), glyph(m_cnt[i] / 16));
        end
      end
      if ($urandom_range(0, 9) < 3) sw8 = 8'($urandom);
      if ($urandom_range(0, 9) < 3) sw16 = 16'($urandom);
      if ($urandom_range(0, 9) < 3) sw2 = 2'($urandom);
      if ($urandom_range(0, 11) == 0) sw8 = 8'h00;
      en   = ($urandom_range(0, 9) != 0);
      hold = ($urandom_range(0, 6) == 0);
      clr  = ($urandom_range(0, 19) == 0);
    end
    hold = 1'b0;
    clr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    hold  = 1'b0;
    clr   = 1'b0;
    sw8   = '0;
    sw16  = '0;
    sw2   = '0;
    test_reset();
    test_latency();
    test_enable();
    test_hold();
    test_wrap_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
